// File: rtl/frq_gen_multi.sv
// Mode-selectable counter generating a terminal-count pulse (co) and a shaped waveform (out).
// co/out are registered and trail the terminal cnt value by one cycle; en=0 freezes the count.
module frq_gen_multi #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             ld,
  input  logic [WIDTH-1:0] div_val,
  input  logic [WIDTH-1:0] duty,
  input  logic [1:0]       mode,
  output logic             co,
  output logic             out,
  output logic [WIDTH-1:0] cnt
);

  typedef enum logic [1:0] {
    M_LOAD   = 2'd0,
    M_FREE   = 2'd1,
    M_SQUARE = 2'd2,
    M_PWM    = 2'd3
  } mode_e;

  localparam logic [WIDTH-1:0] MAX = '1;

  mode_e            mode_in, mode_q, mode_n;
  logic [WIDTH-1:0] div_reg, div_n, cnt_n, reload;
  logic             co_n, out_n;

  assign mode_in = mode_e'(mode);
  // Reload follows the incoming mode so a mode switch restarts from the new mode's origin.
  assign reload  = (mode_in == M_LOAD || mode_in == M_SQUARE) ? div_reg : '0;

  always_comb begin
    cnt_n  = cnt;
    div_n  = div_reg;
    mode_n = mode_q;
    co_n   = 1'b0;
    out_n  = out;
    if (ld) begin
      div_n = div_val;
      cnt_n = div_val;
    end else if (mode_in != mode_q) begin
      mode_n = mode_in;
      cnt_n  = reload;
      out_n  = 1'b0;
    end else if (!en) begin
      if (mode_q == M_LOAD || mode_q == M_FREE) out_n = 1'b0;
    end else begin
      if (cnt == MAX) begin
        cnt_n = reload;
        co_n  = 1'b1;
      end else begin
        cnt_n = cnt + 1'b1;
      end
      case (mode_q)
        M_LOAD, M_FREE: out_n = co_n;
        M_SQUARE:       out_n = co_n ? ~out : out;
        M_PWM:          out_n = (cnt_n < duty);
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      div_reg <= '0;
      mode_q  <= M_LOAD;
      co      <= 1'b0;
      out     <= 1'b0;
    end else begin
      cnt     <= cnt_n;
      div_reg <= div_n;
      mode_q  <= mode_n;
      co      <= co_n;
      out     <= out_n;
    end
  end

endmodule

// File: doc/frq_gen_multi.md
Name: frq_gen_multi

Overview:
- Parametrised, mode-selectable frequency generator.
- Successor to the paired loadable/fixed divider arrangement: one counter core covers loadable divide, free-running divide, square-wave and PWM outputs, selected at runtime.
- Sits between the board clock and downstream tick/LED/buzzer consumers.
- Drives a terminal-count pulse (co) and a shaped waveform (out).

Parameters:
- WIDTH, 8, counter, divisor and duty width; full-scale terminal count MAX = 2^WIDTH-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  count enable; counter holds when low.
- ld  input  1  load strobe; captures div_val into the divisor register and restarts the counter.
- div_val  input  WIDTH  start value for LOAD/SQUARE modes.
- duty  input  WIDTH  PWM compare value, sampled every cycle.
- mode  input  2  0=LOAD, 1=FREE, 2=SQUARE, 3=PWM.
- co  output  1  registered terminal-count pulse.
- out  output  1  registered waveform output.
- cnt  output  WIDTH  current counter value.

Behaviour:
- Reset (rst=0, asynchronous): cnt=0, div_reg=0, mode_q=0, co=0, out=0.
- State: cnt, div_reg, mode_q (registered copy of mode), co, out.
- Terminal event: en=1 and cnt==MAX.
- Reload value: div_reg in LOAD/SQUARE; 0 in FREE/PWM.
- Priority, highest first, evaluated per rising edge:
  1. ld=1: div_reg<=div_val; cnt<=div_val; co<=0; out unchanged. Applies regardless of en. Wins over a simultaneous terminal event; no co pulse is issued that cycle.
  2. mode!=mode_q: mode_q<=mode; cnt<=reload value of the new mode; co<=0; out<=0.
  3. en=0: cnt holds; co<=0; out holds in SQUARE and PWM, out<=0 in LOAD and FREE.
  4. Terminal event: cnt<=reload value; co<=1 for exactly one cycle.
  5. Otherwise: cnt<=cnt+1; co<=0.
- LOAD period = 2^WIDTH - div_reg cycles. div_reg=MAX gives period 1, so co stays high continuously while en=1.
- FREE period = 2^WIDTH cycles; wraps MAX->0.
- out per mode:
  - LOAD, FREE: out<=next co, identical to co.
  - SQUARE: out toggles on every terminal event; out period = 2*(2^WIDTH - div_reg) cycles.
  - PWM: out<=(next cnt < duty), unsigned compare.
    - duty=0: out constantly 0.
    - duty=MAX: out low only while cnt==MAX.
- Latency: co and out are registered; observable one cycle after the terminal count value appears on cnt.
- All arithmetic is unsigned WIDTH-bit; the increment wraps modulo 2^WIDTH (only reachable at MAX, which is handled as terminal).
- Reset asserted mid-count aborts immediately to reset values. After release, counting resumes from 0 in LOAD mode with div_reg=0.

Test Plan (WIDTH=4):
- Reset/idle: hold rst=0 three cycles with en=1, ld=1 -> cnt=0, co=0, out=0; counting from 0 starts on the first edge after release.
- LOAD: ld pulse with div_val=12, mode=0, en=1 -> cnt sequence 12,13,14,15,12,...; co high one cycle in every 4, out==co. Repeat with div_val=15 -> co held high continuously.
- FREE plus enable gating: mode=1 -> co every 16 cycles. Drop en for 5 cycles at cnt=7 -> cnt stays 7, co=0; resumes at 8, so the next co is 5 cycles late.
- SQUARE: mode=2, div_val=10 -> out toggles every 6 cycles (period 12, 50% duty). Switch to mode=3 mid-run -> cnt=0 and out=0 on the next cycle.
- PWM: mode=3 with duty=4 -> out high 4 of every 16 cycles. duty=0 -> out always 0. Change duty to 12 mid-period -> takes effect on the next cycle's compare.
- Collisions: ld asserted in the same cycle cnt==15 (LOAD, div_val=8) -> cnt=8 next, no co pulse that cycle. Assert rst mid-count at cnt=9 -> all outputs 0 immediately, without waiting for a clock edge.
